// File: rtl/rng_pkg.sv
// Shared types and helpers for the random-source arbiter.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DELIVER
  } arb_state_t;

  localparam int RNG_W_DEF = 2;

  function automatic int samples_per_word(input int out_w, input int rng_w);
    return out_w / rng_w;
  endfunction

endpackage

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rng_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   sum;

  // Rotating the doubled vector puts the pointer's requester at bit 0.
  always_comb begin
    dbl    = {req, req};
    rot    = NUM_REQ'(dbl >> ptr);
    valid  = |req;
    winner = '0;
    sum    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = int'(ptr) + i;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end
        winner = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter that packs consecutive random-source samples into a
// wide word for one requester at a time and acknowledges with a 1-cycle pulse.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int RNG_W   = RNG_W_DEF,
  parameter  int OUT_W   = 8,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [RNG_W-1:0]   RNG_IN,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] ACK,
  output logic [OUT_W-1:0]   RAND_OUT,
  output logic [IDX_W-1:0]   GRANT_ID,
  output logic               BUSY
);

  localparam int S     = samples_per_word(OUT_W, RNG_W);
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

  if (OUT_W < RNG_W || (OUT_W % RNG_W) != 0) begin : g_bad_width
    $fatal(1, "rng_arbiter: OUT_W must be a non-zero multiple of RNG_W");
  end
  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $fatal(1, "rng_arbiter: NUM_REQ must be in 1..8");
  end

  arb_state_t         state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [OUT_W-1:0]   rand_q, rand_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [OUT_W-1:0]   acc_shift;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rng_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .winner(pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    rand_d    = rand_q;
    ack_d     = '0;
    acc_shift = OUT_W'({acc_q, RNG_IN});
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        // A withdrawn request abandons the word; pointer and RAND_OUT untouched.
        if (!REQ[grant_q]) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_shift;
          cnt_d = cnt_q + 1'b1;
          // Word and ACK are registered on the last sample so both appear
          // together during the DELIVER cycle.
          if (cnt_q == CNT_W'(S - 1)) begin
            rand_d         = acc_shift;
            ack_d[grant_q] = 1'b1;
            ptr_d          = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d        = DELIVER;
          end
        end
      end
      DELIVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      rand_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rand_q  <= rand_d;
      ack_q   <= ack_d;
    end
  end

  assign ACK      = ack_q;
  assign RAND_OUT = rand_q;
  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares the single free-running 2-bit random source among NUM_REQ game-logic requesters, for example enemy AI, loot and spawn units.
- Serves requests in round-robin order.
- For the granted requester, gathers OUT_W/RNG_W consecutive source samples into one wide random word.
- Returns that word with a one-cycle acknowledge pulse.
- Sits between the random source and all of its consumers.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- RNG_W, 2, width of the random-source sample.
- OUT_W, 8, width of the delivered random word. Must be a multiple of RNG_W and at least RNG_W; violating either is a fatal elaboration error.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous and active-high.
- RNG_IN  in  RNG_W  current sample from the random source; sampled every clock.
- REQ  in  NUM_REQ  level request per requester; held until that requester's ACK.
- ACK  out  NUM_REQ  one-hot, single-cycle pulse marking RAND_OUT valid for the granted requester.
- RAND_OUT  out  OUT_W  delivered random word; holds its value between ACKs.
- GRANT_ID  out  $clog2(NUM_REQ) (minimum 1)  index of the current or last granted requester.
- BUSY  out  1  high while in FILL or DELIVER.

Behaviour:
- Reset, on the next CLK edge with RST=1:
  - State=IDLE, ACK=0, RAND_OUT=0, GRANT_ID=0, BUSY=0.
  - Priority pointer=0, accumulator=0, sample count=0.
  - Applies from any state; an in-flight fill is dropped with no ACK.
- IDLE state:
  - If REQ is nonzero, pick the first set REQ bit starting at the pointer and wrapping upward (round-robin).
  - Register that index into GRANT_ID, clear the accumulator and count, go to FILL.
  - If REQ is zero, stay in IDLE.
- FILL state:
  - Each cycle: acc <= {acc[OUT_W-RNG_W-1:0], RNG_IN}; count += 1.
  - The first sample is the most significant.
  - After S = OUT_W/RNG_W samples, go to DELIVER.
  - If REQ[GRANT_ID] drops during FILL: abort to IDLE, no ACK, pointer unchanged, RAND_OUT unchanged.
  - Other REQ bits changing during FILL have no effect.
- DELIVER state:
  - RAND_OUT <= acc, registered.
  - ACK[GRANT_ID] = 1 for exactly one cycle, in the same cycle RAND_OUT shows the new value.
  - Pointer <= (GRANT_ID+1) mod NUM_REQ.
  - Next state is IDLE.
- Latency:
  - REQ seen in IDLE at cycle t → samples taken at t+1..t+S → ACK at cycle t+S+1.
  - With the defaults, ACK arrives 5 cycles after acceptance.
  - Minimum spacing between ACKs is S+2 cycles.
- Fairness: a requester holding REQ is served within NUM_REQ grants.
- Re-request: a requester still holding REQ in the cycle after its ACK re-enters arbitration at lowest priority.
- NUM_REQ=1: the pointer stays at 0; behaves as a plain sample packer.
- BUSY = (state != IDLE).

Decomposition:
- Package rng_pkg holds:
  - The enum arb_state_t {IDLE, FILL, DELIVER}.
  - The constant RNG_W_DEF=2.
  - A function for samples-per-word.
- One combinational sub-module, rng_rr_pick:
  - Inputs: REQ vector and pointer.
  - Outputs: any-valid flag and the winner index.
  - Uses the double-width mask method.

Test Plan:
- Reset/idle: hold RST for 2 cycles, then REQ=0 for 10 cycles → ACK=0, BUSY=0, RAND_OUT=0x00, GRANT_ID=0 throughout.
- Single request packing:
  - Stimulus: REQ=4'b0001 with RNG_IN driven 1,2,3,0 on the FILL cycles.
  - Response: ACK=4'b0001 exactly 5 cycles after acceptance, RAND_OUT=0x6C, GRANT_ID=0.
- Round-robin order: REQ=4'b1111 held, each requester dropping its bit after its ACK → ACK order 0,1,2,3, with ACK pulses spaced 6 cycles apart.
- Wrap and fairness:
  - Stimulus: pointer at 3 after serving requester 2, then REQ=4'b1001.
  - Response: requester 3 is served first, then requester 0.
- Abort: REQ[1] drops in the 2nd FILL cycle → no ACK, RAND_OUT unchanged, next grant starts still at pointer 1.
- Reset mid-fill: assert RST during the 3rd FILL cycle → next cycle state=IDLE, BUSY=0, pointer=0, no ACK is ever issued for that request.
